sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO: the next generation of the team's 8x8 synchronous FIFO. It adds configurable width, depth and almost-full/almost-empty thresholds, plus an occupancy count, a read-valid strobe, sticky overflow/underflow flags and a synchronous flush. It is the standard buffer between producer/consumer blocks in one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
(local) AW = clog2(DEPTH); pointers are AW bits, count is AW+1 bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
we  input  1  write request
re  input  1  read request
flush  input  1  synchronous clear of contents and sticky flags
din  input  WIDTH  write data
dout  output  WIDTH  read data, registered
valid  output  1  one-cycle pulse: dout updated by an accepted read this cycle
count  output  AW+1  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_THRESH
almost_full  output  1  count >= AF_THRESH
wr_err  output  1  one-cycle pulse: write rejected
rd_err  output  1  one-cycle pulse: read rejected
overflow  output  1  sticky: set on any wr_err
underflow  output  1  sticky: set on any rd_err

Behaviour:
- Reset (async assert, release synchronised by the caller): wr_ptr=rd_ptr=0, count=0, dout=0, valid=0, wr_err=rd_err=0, overflow=underflow=0. Hence empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- All status flags are decoded only from the count register. There is no combinational path from we/re/din to any output.
- Accepted write: din is stored at mem[wr_ptr], wr_ptr increments modulo DEPTH.
- Accepted read: dout <= mem[rd_ptr] on the same edge (1-cycle latency from re). rd_ptr increments modulo DEPTH. valid=1 for that cycle.
- With no accepted read, dout holds its previous value (it does not return to zero) and valid=0.
- Per-cycle decision, evaluated on the pre-edge count:
  - not empty and not full: we and re are each accepted independently. Count: +1 for write only, -1 for read only, unchanged for both.
  - empty, re only: read rejected; rd_err=1, underflow<=1, dout and pointers unchanged.
  - empty, we&re: bypass. dout <= din, valid=1, pointers and count unchanged, no error, memory not written.
  - full, we only: write rejected; wr_err=1, overflow<=1, memory and pointers unchanged.
  - full, we&re: both accepted; count stays DEPTH. The read returns the oldest word, not din.
- wr_err and rd_err are cleared to 0 on every cycle with no rejection.
- flush (priority over we/re, below rst): pointers=0, count=0, overflow=underflow=0, valid=0, errors=0, dout unchanged. Requests in the flush cycle are ignored.
- Pointer wrap: pointers roll over from DEPTH-1 to 0 with no bubble. Ordering is preserved across any number of wraps.
- rst asserted mid-operation: immediate return to reset state. Data in flight is lost.

Test Plan:
(Defaults WIDTH=8, DEPTH=8, AF=6, AE=2.)
- Reset then fill: write 0x01..0x08 on 8 consecutive cycles -> count steps 1..8; almost_empty drops when count=3; almost_full rises when count=6; full=1 after the 8th write.
- Overflow: write 0xAA while full -> wr_err pulses 1 cycle, overflow stays 1, count=8. Then read 8 -> dout 0x01..0x08 in order, valid each cycle, empty=1 after the last read.
- Underflow and bypass: re on empty -> rd_err=1, underflow=1, dout unchanged. Next cycle we&re with din=0x5C -> dout=0x5C, valid=1, count=0, no error.
- Wrap: write 5, read 5, then write 6, read 6 with data 0x10..0x15 -> read order 0x10..0x15 exact; pointers cross index 7->0.
- Simultaneous at full: full FIFO, we&re with din=0x77 -> dout=oldest entry, count=8, no wr_err; 0x77 is read back last.
- Flush and async reset: count=4, overflow=1, pulse flush -> count=0, overflow=0, empty=1. Assert rst between clock edges -> count and flags clear before the next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, a registered read port with a one-cycle valid strobe, per-cycle
// reject pulses, sticky overflow/underflow flags and a synchronous flush.
//
// Parameters
//   WIDTH      data word width in bits (>=1)
//   DEPTH      number of entries, power of two, >=4
//   AF_THRESH  almost_full  asserts when count >= AF_THRESH
//   AE_THRESH  almost_empty asserts when count <= AE_THRESH
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   we / re       write / read request
//   flush         synchronous clear of contents and sticky flags
//   din           write data
//   dout          registered read data (holds when no read is accepted)
//   valid         one-cycle pulse: dout was updated this cycle
//   count         occupancy, 0..DEPTH
//   empty / full  count == 0 / count == DEPTH
//   almost_empty  count <= AE_THRESH
//   almost_full   count >= AF_THRESH
//   wr_err        one-cycle pulse: write rejected (full, write only)
//   rd_err        one-cycle pulse: read rejected (empty, read only)
//   overflow      sticky, set by any wr_err
//   underflow     sticky, set by any rd_err
// -----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic             re,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic             wr_err,
   output logic             rd_err,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_LVL    = (AW+1)'(AE_THRESH);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   logic is_empty;
   logic is_full;
   logic bypass_p0;
   logic wr_acc_p0;
   logic rd_acc_p0;
   logic wr_rej_p0;
   logic rd_rej_p0;

   // ---- stage p0: request decode against the pre-edge occupancy ----
   assign is_empty = (count == '0);
   assign is_full  = (count == DEPTH_LVL);

   always_comb begin
      // Empty with both requests: the incoming word goes straight to dout,
      // memory and pointers are untouched.
      bypass_p0 = is_empty & we & re;
      // When full, a write is only accepted if a read frees the slot on the
      // same edge; wr_ptr == rd_ptr then, and the read sees the old word.
      wr_acc_p0 = we & (~is_full | re) & ~bypass_p0;
      rd_acc_p0 = re & ~is_empty;
      wr_rej_p0 = we & is_full & ~re;
      rd_rej_p0 = re & is_empty & ~we;
   end

   // ---- stage p1: registered state and outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid     <= 1'b0;
         wr_err    <= 1'b0;
         rd_err    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid     <= 1'b0;
         wr_err    <= 1'b0;
         rd_err    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc_p0) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc_p0) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc_p0, rd_acc_p0})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         valid  <= rd_acc_p0 | bypass_p0;
         wr_err <= wr_rej_p0;
         rd_err <= rd_rej_p0;
         if (wr_rej_p0) begin
            overflow <= 1'b1;
         end
         if (rd_rej_p0) begin
            underflow <= 1'b1;
         end
      end
   end

   // dout is cleared by reset but deliberately left alone by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
      end else if (!flush) begin
         if (rd_acc_p0) begin
            dout <= mem[rd_ptr];
         end else if (bypass_p0) begin
            dout <= din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc_p0 && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // ---- status decode from the count register only ----
   assign empty        = is_empty;
   assign full         = is_full;
   assign almost_empty = (count <= AE_LVL);
   assign almost_full  = (count >= AF_LVL);

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2). A queue
// model tracks the FIFO contents and expected outputs; a negedge process
// compares every output each cycle, and literal expectations pin key points.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int AF = 6;
   localparam int AE = 2;

   logic         clk;
   logic         rst;
   logic         we;
   logic         re;
   logic         flush;
   logic [W-1:0] din;
   logic [W-1:0] dout;
   logic         valid;
   logic [3:0]   count;
   logic         empty;
   logic         full;
   logic         almost_empty;
   logic         almost_full;
   logic         wr_err;
   logic         rd_err;
   logic         overflow;
   logic         underflow;

   int checks = 0;
   int errors = 0;

   // behavioural model
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout;
   logic         m_valid;
   logic         m_wr_err;
   logic         m_rd_err;
   logic         m_ovf;
   logic         m_unf;

   sync_fifo_param #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .re(re), .flush(flush), .din(din),
      .dout(dout), .valid(valid), .count(count), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full),
      .wr_err(wr_err), .rd_err(rd_err), .overflow(overflow),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout   = '0;
      m_valid  = 1'b0;
      m_wr_err = 1'b0;
      m_rd_err = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
   endtask

   // One clock edge of FIFO behaviour, from the occupancy before the edge.
   task automatic model_step();
      int n;
      n = q.size();
      m_valid  = 1'b0;
      m_wr_err = 1'b0;
      m_rd_err = 1'b0;
      if (flush) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (n == 0) begin
         if (we && re) begin
            m_dout  = din;
            m_valid = 1'b1;
         end else if (re) begin
            m_rd_err = 1'b1;
            m_unf    = 1'b1;
         end else if (we) begin
            q.push_back(din);
         end
      end else if (n == D) begin
         if (we && re) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
            q.push_back(din);
         end else if (we) begin
            m_wr_err = 1'b1;
            m_ovf    = 1'b1;
         end else if (re) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
         end
      end else begin
         if (re) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
         end
         if (we) begin
            q.push_back(din);
         end
      end
   endtask

   // Drive one cycle of requests, advance the model on the edge, return 1 after.
   task automatic cycle(input logic w, input logic r, input logic f,
                        input logic [W-1:0] d);
      we    = w;
      re    = r;
      flush = f;
      din   = d;
      @(posedge clk);
      model_step();
      #1;
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      chk("dout",         dout,         m_dout);
      chk("valid",        valid,        m_valid);
      chk("count",        count,        q.size());
      chk("empty",        empty,        q.size() == 0);
      chk("full",         full,         q.size() == D);
      chk("almost_empty", almost_empty, q.size() <= AE);
      chk("almost_full",  almost_full,  q.size() >= AF);
      chk("wr_err",       wr_err,       m_wr_err);
      chk("rd_err",       rd_err,       m_rd_err);
      chk("overflow",     overflow,     m_ovf);
      chk("underflow",    underflow,    m_unf);
   end

   initial begin
      rst   = 1'b1;
      we    = 1'b0;
      re    = 1'b0;
      flush = 1'b0;
      din   = '0;
      model_reset();
      @(negedge clk);
      #2;
      chk("rst_count",  count,        0);
      chk("rst_empty",  empty,        1);
      chk("rst_ae",     almost_empty, 1);
      chk("rst_full",   full,         0);
      chk("rst_af",     almost_full,  0);
      chk("rst_dout",   dout,         0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // fill 0x01..0x08
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'b0, W'(i + 1));
         chk("fill_count", count, i + 1);
         if (i == 1) chk("ae_at_2", almost_empty, 1);
         if (i == 2) chk("ae_at_3", almost_empty, 0);
         if (i == 4) chk("af_at_5", almost_full, 0);
         if (i == 5) chk("af_at_6", almost_full, 1);
      end
      chk("fill_full", full, 1);

      // overflow
      cycle(1'b1, 1'b0, 1'b0, 8'hAA);
      chk("ovf_wr_err", wr_err, 1);
      chk("ovf_flag", overflow, 1);
      chk("ovf_count", count, 8);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ovf_pulse_end", wr_err, 0);
      chk("ovf_sticky", overflow, 1);

      // drain in order
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         chk("drain_dout", dout, i + 1);
         chk("drain_valid", valid, 1);
      end
      chk("drain_empty", empty, 1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("idle_valid", valid, 0);
      chk("idle_dout_hold", dout, 8'h08);

      // underflow, then bypass
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("unf_rd_err", rd_err, 1);
      chk("unf_flag", underflow, 1);
      chk("unf_dout", dout, 8'h08);
      cycle(1'b1, 1'b1, 1'b0, 8'h5C);
      chk("byp_dout", dout, 8'h5C);
      chk("byp_valid", valid, 1);
      chk("byp_count", count, 0);
      chk("byp_rd_err", rd_err, 0);

      // wrap: pointers go 0->5, then 5->11 (crossing 7->0)
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'hE0 + i));
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         chk("wrap1_dout", dout, 8'hE0 + i);
      end
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'h10 + i));
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         chk("wrap2_dout", dout, 8'h10 + i);
      end

      // simultaneous read/write at full
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'h20 + i));
      cycle(1'b1, 1'b1, 1'b0, 8'h77);
      chk("full_rw_dout", dout, 8'h20);
      chk("full_rw_count", count, 8);
      chk("full_rw_wr_err", wr_err, 0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 8'h00);
         chk("full_rw_order", dout, (i < 7) ? (8'h21 + i) : 8'h77);
      end
      chk("full_rw_empty", empty, 1);

      // flush with requests present
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'h30 + i));
      chk("pre_flush_count", count, 4);
      chk("pre_flush_ovf", overflow, 1);
      cycle(1'b1, 1'b1, 1'b1, 8'h99);
      chk("flush_count", count, 0);
      chk("flush_ovf", overflow, 0);
      chk("flush_unf", underflow, 0);
      chk("flush_empty", empty, 1);
      chk("flush_dout", dout, 8'h77);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // asynchronous reset between edges
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'h50 + i));
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("pre_rst_dout", dout, 8'h50);
      #2;
      we  = 1'b0;
      re  = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_dout", dout, 0);
      chk("arst_valid", valid, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 1'b0, 8'h42);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("post_rst_dout", dout, 8'h42);
      chk("post_rst_valid", valid, 1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
